// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that streams a start address and data bytes into a byte memory.
// All SPI pins are oversampled in the clk domain; writes auto-increment and wrap at M.
module spi_mem_loader #(
  parameter int M  = 164,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sclk,
  input  logic          spi_cs_n,
  input  logic          spi_mosi,
  output logic [N-1:0]  mem_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          frame_done,
  output logic          addr_err,
  output logic [AW:0]   byte_count
);

  localparam int SW = (N > 8) ? N : 8;
  localparam int CW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sclk_sync_q;
  logic [2:0]      cs_sync_q;
  logic [1:0]      mosi_sync_q;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [N-1:0]    mem_data_q, mem_data_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic            frame_done_q, frame_done_d;
  logic            addr_err_q, addr_err_d;
  logic [AW:0]     byte_count_q, byte_count_d;

  logic            sclk_rise_s, cs_fall_s, cs_rise_s, mosi_s;
  logic [SW-1:0]   shift_in_s;
  logic [7:0]      addr_byte_s;

  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s      = mosi_sync_q[1];
  assign shift_in_s  = {shift_q[SW-2:0], mosi_s};
  assign addr_byte_s = shift_in_s[7:0];

  // Synchronizers and all state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= 3'b111;
      cs_sync_q    <= 3'b111;
      mosi_sync_q  <= 2'b00;
      state_q      <= IDLE;
      shift_q      <= {SW{1'b0}};
      bit_cnt_q    <= {CW{1'b0}};
      mem_data_q   <= {N{1'b0}};
      mem_addr_q   <= {AW{1'b0}};
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      byte_count_q <= {(AW+1){1'b0}};
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q    <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      mem_data_q   <= mem_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      frame_done_q <= frame_done_d;
      addr_err_q   <= addr_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Frame sequencing, shifting and write generation.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    mem_data_d   = mem_data_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    frame_done_d = 1'b0;
    addr_err_d   = addr_err_q;
    byte_count_d = byte_count_q;

    // Advance to the next address once the strobe has been seen by the memory.
    if (mem_we_q) begin
      if (mem_addr_q == AW'(M - 1)) begin
        mem_addr_d = {AW{1'b0}};
      end else begin
        mem_addr_d = mem_addr_q + AW'(1);
      end
    end else begin
      mem_addr_d = mem_addr_q;
    end

    if ((state_q != IDLE) && cs_rise_s) begin
      // CS release wins over a byte completing in the same cycle.
      state_d      = IDLE;
      bit_cnt_d    = {CW{1'b0}};
      frame_done_d = (byte_count_q != {(AW+1){1'b0}});
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            state_d      = ADDR;
            shift_d      = {SW{1'b0}};
            bit_cnt_d    = {CW{1'b0}};
            byte_count_d = {(AW+1){1'b0}};
            addr_err_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        ADDR: begin
          if (sclk_rise_s) begin
            shift_d = shift_in_s;
            if (bit_cnt_q == CW'(7)) begin
              bit_cnt_d = {CW{1'b0}};
              if ({24'd0, addr_byte_s} < 32'(M)) begin
                mem_addr_d = AW'(addr_byte_s);
                state_d    = DATA;
              end else begin
                addr_err_d = 1'b1;
                state_d    = DISCARD;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            state_d = ADDR;
          end
        end
        DATA: begin
          if (sclk_rise_s) begin
            shift_d = shift_in_s;
            if (bit_cnt_q == CW'(N - 1)) begin
              bit_cnt_d  = {CW{1'b0}};
              mem_data_d = shift_in_s[N-1:0];
              mem_we_d   = 1'b1;
              if (byte_count_q != {(AW+1){1'b1}}) begin
                byte_count_d = byte_count_q + (AW+1)'(1);
              end else begin
                byte_count_d = byte_count_q;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            state_d = DATA;
          end
        end
        DISCARD: begin
          state_d = DISCARD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign mem_data   = mem_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign frame_done = frame_done_q;
  assign addr_err   = addr_err_q;
  assign byte_count = byte_count_q;

endmodule
